// File: rtl/led_matrix_pkg.sv
// Shared definitions for the 8x8 LED matrix row-scan controller:
// matrix geometry, scan FSM state encoding and a row-decode helper.
package led_matrix_pkg;

   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int ROW_W = 3;
   localparam int BIT_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BLANK    = 3'd1,
      ST_SHIFT_LO = 3'd2,
      ST_SHIFT_HI = 3'd3,
      ST_LATCH    = 3'd4,
      ST_HOLD     = 3'd5
   } scan_state_t;

   // One-hot row drive pattern for a row index (row 0 -> bit 0).
   function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
      logic [ROWS-1:0] pattern;
      pattern = {{(ROWS-1){1'b0}}, 1'b1} << row;
      return pattern;
   endfunction

endpackage

// File: rtl/led_scan_tick_gen.sv
// Scan tick generator: a free-running divider that produces a one-cycle
// tick every CLK_DIV clocks. All scan FSM steps advance on this tick.
module led_scan_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_r;

   // Divider counter: runs 0..CLK_DIV-1 and wraps; cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (count_r == CNT_MAX) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + CNT_ONE;
      end
   end

   assign tick = (count_r == CNT_MAX);

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan scheduler for the 8x8 LED matrix. Holds a double-buffered frame,
// shifts each front-bank row MSB-first to the column shift register, latches
// it, then lights that row for HOLD_TICKS ticks. Bank swaps are deferred to
// the frame boundary (or done at once while idle) so frames never tear.
module led_matrix_scan_ctrl
   import led_matrix_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int HOLD_TICKS = 64
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             enable_in,
   input  logic             wr_en_in,
   input  logic [ROW_W-1:0] wr_row_in,
   input  logic [COLS-1:0]  wr_data_in,
   input  logic             swap_req_in,
   output logic             swap_ack_out,
   output logic             frame_start_out,
   output logic             ser_data_out,
   output logic             ser_clk_out,
   output logic             latch_out,
   output logic [ROWS-1:0]  row_sel_out
);

   localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
   localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(COLS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   scan_state_t      state_r, state_s;
   logic [ROW_W-1:0] row_r, row_s;
   logic [BIT_W-1:0] bit_r, bit_s;
   logic [COLS-1:0]  sreg_r, sreg_s;
   logic [HOLD_W-1:0] hold_r, hold_s;
   logic             front_sel_r, front_sel_s;
   logic             pending_r, pending_s;
   logic             swap_exec_s;
   logic             tick_s;
   logic             ser_data_s, ser_clk_s, latch_s, frame_start_s, swap_ack_s;
   logic [ROWS-1:0]  row_sel_s;
   logic [COLS-1:0]  front_row_s;

   // Two banks of ROWS rows; bank front_sel_r is displayed, the other is written.
   logic [COLS-1:0]  bank_r [2][ROWS];

   led_scan_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .tick  (tick_s)
   );

   assign front_row_s = bank_r[front_sel_r][row_r];

   // Frame-buffer write port: always into the bank not currently displayed,
   // judged by front_sel before this edge, so a write coincident with a swap
   // lands in the bank that becomes front.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) begin
               bank_r[b][r] <= '0;
            end
         end
      end else if (wr_en_in) begin
         bank_r[~front_sel_r][wr_row_in] <= wr_data_in;
      end else begin
         bank_r <= bank_r;
      end
   end

   // Next-state, next-output and swap bookkeeping for the scan FSM.
   always_comb begin
      state_s       = state_r;
      row_s         = row_r;
      bit_s         = bit_r;
      sreg_s        = sreg_r;
      hold_s        = hold_r;
      ser_data_s    = ser_data_out;
      ser_clk_s     = ser_clk_out;
      latch_s       = latch_out;
      row_sel_s     = row_sel_out;
      frame_start_s = 1'b0;
      swap_exec_s   = 1'b0;

      if ((state_r != ST_IDLE) && tick_s && !enable_in) begin
         // Disable aborts the scan on the tick and blanks everything.
         state_s    = ST_IDLE;
         row_s      = '0;
         bit_s      = '0;
         hold_s     = '0;
         ser_data_s = 1'b0;
         ser_clk_s  = 1'b0;
         latch_s    = 1'b0;
         row_sel_s  = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               row_s       = '0;
               ser_data_s  = 1'b0;
               ser_clk_s   = 1'b0;
               latch_s     = 1'b0;
               row_sel_s   = '0;
               // While idle there is no frame to protect: swap immediately.
               swap_exec_s = pending_r;
               if (tick_s && enable_in) begin
                  state_s       = ST_BLANK;
                  frame_start_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_BLANK: begin
               if (tick_s) begin
                  sreg_s     = front_row_s;
                  bit_s      = BIT_MSB;
                  ser_clk_s  = 1'b0;
                  ser_data_s = front_row_s[COLS-1];
                  state_s    = ST_SHIFT_LO;
               end else begin
                  state_s = ST_BLANK;
               end
            end
            ST_SHIFT_LO: begin
               if (tick_s) begin
                  ser_clk_s = 1'b1;
                  state_s   = ST_SHIFT_HI;
               end else begin
                  state_s = ST_SHIFT_LO;
               end
            end
            ST_SHIFT_HI: begin
               if (tick_s) begin
                  sreg_s    = sreg_r << 3'd1;
                  ser_clk_s = 1'b0;
                  if (bit_r == '0) begin
                     ser_data_s = 1'b0;
                     latch_s    = 1'b1;
                     state_s    = ST_LATCH;
                  end else begin
                     bit_s      = bit_r - BIT_ONE;
                     ser_data_s = sreg_s[COLS-1];
                     state_s    = ST_SHIFT_LO;
                  end
               end else begin
                  state_s = ST_SHIFT_HI;
               end
            end
            ST_LATCH: begin
               if (tick_s) begin
                  latch_s   = 1'b0;
                  hold_s    = '0;
                  row_sel_s = row_onehot(row_r);
                  state_s   = ST_HOLD;
               end else begin
                  state_s = ST_LATCH;
               end
            end
            ST_HOLD: begin
               if (tick_s) begin
                  if (hold_r == HOLD_LAST) begin
                     hold_s    = '0;
                     row_sel_s = '0;
                     state_s   = ST_BLANK;
                     if (row_r == ROW_LAST) begin
                        // Frame boundary: the only point a running scan swaps.
                        row_s         = '0;
                        frame_start_s = 1'b1;
                        swap_exec_s   = pending_r;
                     end else begin
                        row_s = row_r + ROW_ONE;
                     end
                  end else begin
                     hold_s = hold_r + HOLD_ONE;
                  end
               end else begin
                  state_s = ST_HOLD;
               end
            end
            default: begin
               state_s    = ST_IDLE;
               row_s      = '0;
               ser_data_s = 1'b0;
               ser_clk_s  = 1'b0;
               latch_s    = 1'b0;
               row_sel_s  = '0;
            end
         endcase
      end

      // An executing swap consumes any request arriving on the same edge.
      if (swap_exec_s) begin
         front_sel_s = ~front_sel_r;
         pending_s   = 1'b0;
         swap_ack_s  = 1'b1;
      end else begin
         front_sel_s = front_sel_r;
         pending_s   = pending_r | swap_req_in;
         swap_ack_s  = 1'b0;
      end
   end

   // Scan state, swap bookkeeping and registered pin outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_r         <= ST_IDLE;
         row_r           <= '0;
         bit_r           <= '0;
         sreg_r          <= '0;
         hold_r          <= '0;
         front_sel_r     <= 1'b0;
         pending_r       <= 1'b0;
         ser_data_out    <= 1'b0;
         ser_clk_out     <= 1'b0;
         latch_out       <= 1'b0;
         row_sel_out     <= '0;
         frame_start_out <= 1'b0;
         swap_ack_out    <= 1'b0;
      end else begin
         state_r         <= state_s;
         row_r           <= row_s;
         bit_r           <= bit_s;
         sreg_r          <= sreg_s;
         hold_r          <= hold_s;
         front_sel_r     <= front_sel_s;
         pending_r       <= pending_s;
         ser_data_out    <= ser_data_s;
         ser_clk_out     <= ser_clk_s;
         latch_out       <= latch_s;
         row_sel_out     <= row_sel_s;
         frame_start_out <= frame_start_s;
         swap_ack_out    <= swap_ack_s;
      end
   end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl (CLK_DIV=2, HOLD_TICKS=4:
// 44 clocks per row, 352 per frame). A negedge monitor decodes the serial
// column stream and pulse counts; tests compare against hand-computed values.
module tb_led_matrix_scan_ctrl;

   localparam int CLK_DIV    = 2;
   localparam int HOLD_TICKS = 4;
   localparam int HOLD_CLKS  = HOLD_TICKS * CLK_DIV;         // 8
   localparam int GAP_CLKS   = 18 * CLK_DIV;                 // 36
   localparam int FRAME_CLKS = 8 * (18 + HOLD_TICKS) * CLK_DIV; // 352

   logic       clk_in      = 1'b0;
   logic       rst_n_in    = 1'b0;
   logic       enable_in   = 1'b0;
   logic       wr_en_in    = 1'b0;
   logic [2:0] wr_row_in   = 3'd0;
   logic [7:0] wr_data_in  = 8'd0;
   logic       swap_req_in = 1'b0;
   logic       swap_ack_out, frame_start_out, ser_data_out, ser_clk_out, latch_out;
   logic [7:0] row_sel_out;

   led_matrix_scan_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .HOLD_TICKS (HOLD_TICKS)
   ) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .enable_in       (enable_in),
      .wr_en_in        (wr_en_in),
      .wr_row_in       (wr_row_in),
      .wr_data_in      (wr_data_in),
      .swap_req_in     (swap_req_in),
      .swap_ack_out    (swap_ack_out),
      .frame_start_out (frame_start_out),
      .ser_data_out    (ser_data_out),
      .ser_clk_out     (ser_clk_out),
      .latch_out       (latch_out),
      .row_sel_out     (row_sel_out)
   );

   // Free-running 100 MHz clock.
   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] rsel;
   } row_vec_t;

   row_vec_t   tbl [8];
   logic [7:0] t2  [8];

   int checks = 0;
   int errors = 0;

   int         cyc = 0;
   logic [7:0] col_sh = 8'd0;
   logic [7:0] latched = 8'd0;
   logic       prev_sclk = 1'b0;
   logic       prev_latch = 1'b0;
   int         n_latch = 0, n_ack = 0, n_fs = 0, last_fs = 0, fs_period = 0;
   int         latch_len = 0, last_latch_len = 0, rowsel_bad = 0;

   // Clock-cycle counter used to time frame_start spacing.
   always @(posedge clk_in) cyc <= cyc + 1;

   // Output monitor: column shift-register model, pulse counters, row_sel sanity.
   always @(negedge clk_in) begin
      if (ser_clk_out && !prev_sclk) col_sh = {col_sh[6:0], ser_data_out};
      if (latch_out && !prev_latch) begin
         latched = col_sh;
         n_latch++;
      end
      if (latch_out) latch_len++;
      if (!latch_out && prev_latch) begin
         last_latch_len = latch_len;
         latch_len = 0;
      end
      if (swap_ack_out) n_ack++;
      if (frame_start_out) begin
         fs_period = cyc - last_fs;
         last_fs = cyc;
         n_fs++;
      end
      if (row_sel_out != 8'd0 &&
          ($countones(row_sel_out) != 1 || latch_out || ser_clk_out || frame_start_out))
         rowsel_bad++;
      prev_sclk  = ser_clk_out;
      prev_latch = latch_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [12:0] outs();
      return {row_sel_out, ser_clk_out, ser_data_out, latch_out, swap_ack_out, frame_start_out};
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic write_row(input logic [2:0] r, input logic [7:0] d);
      wr_en_in = 1'b1; wr_row_in = r; wr_data_in = d;
      step(1);
      wr_en_in = 1'b0;
   endtask

   task automatic pulse_swap();
      swap_req_in = 1'b1;
      step(1);
      swap_req_in = 1'b0;
   endtask

   // Waits for the next lit row; returns its drive, the latched byte, lit time and dark gap.
   task automatic wait_lit(output logic [7:0] rsel, output logic [7:0] data,
                           output int hold_len, output int gap);
      int n = 0;
      while (row_sel_out != 8'd0 && n < 600) begin @(negedge clk_in); n++; end
      gap = 0;
      while (row_sel_out == 8'd0 && n < 600) begin @(negedge clk_in); n++; gap++; end
      rsel = row_sel_out;
      data = latched;
      hold_len = 0;
      while (row_sel_out == rsel && rsel != 8'd0 && n < 600) begin
         @(negedge clk_in); n++; hold_len++;
      end
      check("wait_lit_timeout", (n < 600) ? 1 : 0, 1);
   endtask

   task automatic wait_row(input logic [7:0] want, output logic [7:0] data);
      logic [7:0] rs;
      int h, g, k;
      k = 0;
      rs = 8'd0;
      data = 8'd0;
      while (rs != want && k < 10) begin
         wait_lit(rs, data, h, g);
         k++;
      end
      check("wait_row_found", rs, want);
   endtask

   task automatic check_quiet(input string name, input int ncyc);
      int busy = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk_in);
         if (outs() != 13'd0) busy++;
      end
      check(name, busy, 0);
   endtask

   task automatic wait_sclk(input logic level);
      int n = 0;
      while (ser_clk_out !== level && n < 40) begin @(negedge clk_in); n++; end
      check("wait_sclk_timeout", (n < 40) ? 1 : 0, 1);
   endtask

   initial begin
      logic [7:0] rs, d;
      int h, g, a0, f0, l0;

      tbl[0] = '{data: 8'h81, rsel: 8'h01};
      tbl[1] = '{data: 8'h42, rsel: 8'h02};
      tbl[2] = '{data: 8'h24, rsel: 8'h04};
      tbl[3] = '{data: 8'h18, rsel: 8'h08};
      tbl[4] = '{data: 8'hFF, rsel: 8'h10};
      tbl[5] = '{data: 8'h00, rsel: 8'h20};
      tbl[6] = '{data: 8'h5A, rsel: 8'h40};
      tbl[7] = '{data: 8'hC3, rsel: 8'h80};
      t2[0] = 8'h11; t2[1] = 8'h22; t2[2] = 8'h33; t2[3] = 8'h44;
      t2[4] = 8'h55; t2[5] = 8'h66; t2[6] = 8'h77; t2[7] = 8'h88;

      // Power-on reset.
      step(3);
      check("reset_outputs", outs(), 13'd0);
      rst_n_in = 1'b1;
      check_quiet("idle_after_reset", 10);

      // A5 into back row 0, idle swap, then scan row 0.
      step(1);
      write_row(3'd0, 8'hA5);
      swap_req_in = 1'b1;
      step(1);
      swap_req_in = 1'b0;
      check("idle_swap_ack_early", swap_ack_out, 1'b0);
      step(1);
      check("idle_swap_ack", swap_ack_out, 1'b1);
      step(1);
      check("idle_swap_ack_width", swap_ack_out, 1'b0);
      f0 = n_fs; l0 = n_latch;
      enable_in = 1'b1;
      wait_lit(rs, d, h, g);
      check("row0_rsel", rs, 8'h01);
      check("row0_serial_A5", d, 8'hA5);
      check("row0_hold_clks", h, HOLD_CLKS);
      check("row0_latch_count", n_latch - l0, 1);
      check("row0_latch_width", last_latch_len, CLK_DIV);
      check("row0_frame_start", n_fs - f0, 1);

      // Table frame: load back bank while idle, swap, scan two frames.
      enable_in = 1'b0;
      step(4);
      for (int i = 0; i < 8; i++) write_row(i[2:0], tbl[i].data);
      a0 = n_ack;
      pulse_swap();
      step(4);
      check("tbl_swap_ack", n_ack - a0, 1);
      enable_in = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 8; i++) begin
            wait_lit(rs, d, h, g);
            check("tbl_rsel", rs, tbl[i].rsel);
            check("tbl_data", d, tbl[i].data);
            check("tbl_hold", h, HOLD_CLKS);
            if (f != 0 || i != 0) check("tbl_gap", g, GAP_CLKS);
            if (f == 1 && i == 0) check("frame_period", fs_period, FRAME_CLKS);
         end
      end

      // Running swap requested (twice) during row 3: takes effect at next frame.
      for (int i = 0; i < 8; i++) write_row(i[2:0], t2[i]);
      wait_row(8'h04, d);
      a0 = n_ack;
      pulse_swap();
      step(5);
      pulse_swap();
      for (int i = 3; i < 8; i++) begin
         wait_lit(rs, d, h, g);
         check("old_rows_rsel", rs, tbl[i].rsel);
         check("old_rows_data", d, tbl[i].data);
      end
      check("no_ack_before_boundary", n_ack - a0, 0);
      for (int i = 0; i < 2; i++) begin
         wait_lit(rs, d, h, g);
         check("new_rows_rsel", rs, tbl[i].rsel);
         check("new_rows_data", d, t2[i]);
      end
      check("boundary_single_ack", n_ack - a0, 1);

      // Disable during SHIFT_LO of row 2, then restart from row 0.
      wait_row(8'h02, d);
      wait_sclk(1'b1);
      wait_sclk(1'b0);
      enable_in = 1'b0;
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      check("disable_blank", outs(), 13'd0);
      check_quiet("disable_idle", 20);
      f0 = n_fs;
      enable_in = 1'b1;
      wait_lit(rs, d, h, g);
      check("restart_rsel", rs, 8'h01);
      check("restart_data", d, t2[0]);
      check("restart_frame_start", n_fs - f0, 1);

      // Write and repeat request on the executing idle-swap edge.
      enable_in = 1'b0;
      step(4);
      a0 = n_ack;
      swap_req_in = 1'b1;
      step(1);
      wr_en_in = 1'b1; wr_row_in = 3'd5; wr_data_in = 8'h3C;
      step(1);
      swap_req_in = 1'b0; wr_en_in = 1'b0;
      step(10);
      check("coincident_single_ack", n_ack - a0, 1);
      enable_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_lit(rs, d, h, g);
         check("coinc_rsel", rs, tbl[i].rsel);
         if (i == 0) check("coinc_row0", d, tbl[0].data);
         if (i == 5) check("coinc_row5", d, 8'h3C);
      end

      // Reset during SHIFT_HI of row 5 aborts at once and clears the banks.
      wait_row(8'h10, d);
      wait_sclk(1'b1);
      a0 = n_ack;
      rst_n_in = 1'b0;
      enable_in = 1'b0;
      @(posedge clk_in);
      #1;
      check("midscan_reset_outputs", outs(), 13'd0);
      step(2);
      rst_n_in = 1'b1;
      check_quiet("post_reset_idle", 10);
      enable_in = 1'b1;
      wait_lit(rs, d, h, g);
      check("post_reset_rsel", rs, 8'h01);
      check("post_reset_cleared", d, 8'h00);
      check("post_reset_no_ack", n_ack - a0, 0);

      check("rowsel_dark_outside_hold", rowsel_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
